// File: rtl/npc_exec_ctrl_if.sv
// Instruction-memory fetch bus: valid/ready request channel plus a valid-only response pulse.
interface npc_exec_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/npc_exec_ctrl.sv
// Multi-cycle fetch/execute sequencer for the NPC datapath: REQ -> WAIT -> EXEC per instruction,
// halting on ebreak, a misaligned next PC, or a fetch that never answers.
module npc_exec_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 32,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  npc_exec_ctrl_if.master      imem,
  output logic [31:0]          dp_pc,
  output logic [31:0]          dp_instruction,
  output logic                 dp_wen,
  input  logic [31:0]          dp_next_pc,
  output logic                 halted,
  output logic [1:0]           halt_code,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instret
);

  localparam logic [31:0]      INST_NOP    = 32'h0000_0013;
  localparam logic [31:0]      INST_EBREAK = 32'h0010_0073;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EXEC,
    S_HALT
  } state_t;

  state_t           state_reg,   state_next;
  logic [31:0]      pc_reg,      pc_next;
  logic [31:0]      inst_reg,    inst_next;
  logic [1:0]       code_reg,    code_next;
  logic [CNT_W-1:0] cycle_reg,   cycle_next;
  logic [CNT_W-1:0] instret_reg, instret_next;
  logic [7:0]       to_cnt_reg,  to_cnt_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      pc_reg      <= RESET_PC;
      inst_reg    <= INST_NOP;
      code_reg    <= 2'd0;
      cycle_reg   <= '0;
      instret_reg <= '0;
      to_cnt_reg  <= 8'd0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      inst_reg    <= inst_next;
      code_reg    <= code_next;
      cycle_reg   <= cycle_next;
      instret_reg <= instret_next;
      to_cnt_reg  <= to_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    inst_next    = inst_reg;
    code_next    = code_reg;
    cycle_next   = cycle_reg;
    instret_next = instret_reg;
    to_cnt_next  = to_cnt_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_REQ;
      end

      S_REQ: begin
        cycle_next = cycle_reg + CNT_ONE;
        if (imem.req_ready) begin
          state_next  = S_WAIT;
          to_cnt_next = 8'd0;
        end
      end

      S_WAIT: begin
        cycle_next = cycle_reg + CNT_ONE;
        if (imem.rsp_valid) begin
          inst_next  = imem.rsp_data;
          state_next = S_EXEC;
        end else begin
          to_cnt_next = to_cnt_reg + 8'd1;
          // The increment that lands on TIMEOUT is the one that gives up.
          if (to_cnt_reg == TIMEOUT - 8'd1) begin
            state_next = S_HALT;
            code_next  = 2'd3;
          end
        end
      end

      S_EXEC: begin
        cycle_next = cycle_reg + CNT_ONE;
        if (inst_reg == INST_EBREAK) begin
          instret_next = instret_reg + CNT_ONE;
          state_next   = S_HALT;
          code_next    = 2'd1;
        end else if (dp_next_pc[1:0] != 2'b00) begin
          // The write still happens; only the PC commit is refused.
          state_next = S_HALT;
          code_next  = 2'd2;
        end else begin
          pc_next      = dp_next_pc;
          instret_next = instret_reg + CNT_ONE;
          state_next   = S_REQ;
        end
      end

      S_HALT: begin
        if (start) begin
          state_next   = S_REQ;
          pc_next      = RESET_PC;
          cycle_next   = '0;
          instret_next = '0;
          code_next    = 2'd0;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign imem.req_valid = (state_reg == S_REQ);
  assign imem.req_addr  = pc_reg;
  assign dp_pc          = pc_reg;
  assign dp_instruction = inst_reg;
  assign dp_wen         = (state_reg == S_EXEC) && (inst_reg != INST_EBREAK);
  assign halted         = (state_reg == S_HALT);
  assign halt_code      = code_reg;
  assign cycle_cnt      = cycle_reg;
  assign instret        = instret_reg;

endmodule

// File: tb/tb_npc_exec_ctrl.sv
// Directed bench for npc_exec_ctrl: inputs change and outputs are checked on the falling edge.
module tb_npc_exec_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dp_pc;
  logic [31:0] dp_instruction;
  logic        dp_wen;
  logic [31:0] dp_next_pc;
  logic        halted;
  logic [1:0]  halt_code;
  logic [31:0] cycle_cnt;
  logic [31:0] instret;

  int vectors     = 0;
  int miscompares = 0;

  npc_exec_ctrl_if imem_bus ();

  npc_exec_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .imem           (imem_bus),
    .dp_pc          (dp_pc),
    .dp_instruction (dp_instruction),
    .dp_wen         (dp_wen),
    .dp_next_pc     (dp_next_pc),
    .halted         (halted),
    .halt_code      (halt_code),
    .cycle_cnt      (cycle_cnt),
    .instret        (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_valid"}, 32'(imem_bus.req_valid), 32'd0);
    chk({tag, " dp_pc"},     dp_pc,                   32'h8000_0000);
    chk({tag, " inst"},      dp_instruction,          32'h0000_0013);
    chk({tag, " wen"},       32'(dp_wen),             32'd0);
    chk({tag, " halted"},    32'(halted),             32'd0);
    chk({tag, " code"},      32'(halt_code),          32'd0);
    chk({tag, " cycle"},     cycle_cnt,               32'd0);
    chk({tag, " instret"},   instret,                 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; dp_next_pc = 32'h0;
    imem_bus.req_ready = 1'b0; imem_bus.rsp_valid = 1'b0; imem_bus.rsp_data = 32'h0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");

    // Zero-wait fetch of addi x1,x0,5
    rst = 1'b1; start = 1'b1; imem_bus.req_ready = 1'b1;
    @(negedge clk);
    chk("t1 req_valid", 32'(imem_bus.req_valid), 32'd1);
    chk("t1 req_addr",  imem_bus.req_addr, 32'h8000_0000);
    start = 1'b0;
    @(negedge clk);
    chk("t1 wait no req", 32'(imem_bus.req_valid), 32'd0);
    imem_bus.req_ready = 1'b0; imem_bus.rsp_valid = 1'b1; imem_bus.rsp_data = 32'h0050_0093;
    @(negedge clk);
    imem_bus.rsp_valid = 1'b0;
    dp_next_pc = 32'h8000_0004;
    chk("t1 exec wen",  32'(dp_wen), 32'd1);
    chk("t1 exec inst", dp_instruction, 32'h0050_0093);
    @(negedge clk);
    chk("t1 wen pulse",  32'(dp_wen), 32'd0);
    chk("t1 pc",         dp_pc, 32'h8000_0004);
    chk("t1 instret",    instret, 32'd1);
    chk("t1 cycle",      cycle_cnt, 32'd3);
    chk("t1 next req",   32'(imem_bus.req_valid), 32'd1);

    // Ready held low for 4 REQ cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2 req_valid held", 32'(imem_bus.req_valid), 32'd1);
      chk("t2 addr stable",    imem_bus.req_addr, 32'h8000_0004);
    end
    chk("t2 cycle", cycle_cnt, 32'd7);
    imem_bus.req_ready = 1'b1;
    @(negedge clk);
    chk("t2 accepted", 32'(imem_bus.req_valid), 32'd0);

    // ebreak
    imem_bus.req_ready = 1'b0; imem_bus.rsp_valid = 1'b1; imem_bus.rsp_data = 32'h0010_0073;
    @(negedge clk);
    imem_bus.rsp_valid = 1'b0;
    dp_next_pc = 32'h8000_0008;
    chk("t3 ebreak no wen", 32'(dp_wen), 32'd0);
    @(negedge clk);
    chk("t3 halted",  32'(halted), 32'd1);
    chk("t3 code",    32'(halt_code), 32'd1);
    chk("t3 pc",      dp_pc, 32'h8000_0004);
    chk("t3 instret", instret, 32'd2);
    chk("t3 cycle",   cycle_cnt, 32'd10);
    imem_bus.req_ready = 1'b1; imem_bus.rsp_valid = 1'b1; imem_bus.rsp_data = 32'hdead_beef;
    @(negedge clk);
    imem_bus.req_ready = 1'b0; imem_bus.rsp_valid = 1'b0;
    chk("t3 stray ready/rsp halted", 32'(halted), 32'd1);
    chk("t3 stray rsp ignored",      dp_instruction, 32'h0010_0073);
    start = 1'b1;
    @(negedge clk);
    chk("t3 restart pc",      dp_pc, 32'h8000_0000);
    chk("t3 restart cycle",   cycle_cnt, 32'd0);
    chk("t3 restart instret", instret, 32'd0);
    chk("t3 restart code",    32'(halt_code), 32'd0);
    chk("t3 restart req",     32'(imem_bus.req_valid), 32'd1);

    // jalr to a misaligned target
    start = 1'b0; imem_bus.req_ready = 1'b1;
    @(negedge clk);
    imem_bus.req_ready = 1'b0; imem_bus.rsp_valid = 1'b1; imem_bus.rsp_data = 32'h0000_8067;
    @(negedge clk);
    imem_bus.rsp_valid = 1'b0;
    dp_next_pc = 32'h8000_0102;
    chk("t4 exec wen", 32'(dp_wen), 32'd1);
    @(negedge clk);
    chk("t4 halted",  32'(halted), 32'd1);
    chk("t4 code",    32'(halt_code), 32'd2);
    chk("t4 pc",      dp_pc, 32'h8000_0000);
    chk("t4 instret", instret, 32'd0);
    chk("t4 cycle",   cycle_cnt, 32'd3);

    // Fetch timeout: 255 silent WAIT cycles
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; imem_bus.req_ready = 1'b1;
    @(negedge clk);
    imem_bus.req_ready = 1'b0;
    repeat (254) @(negedge clk);
    chk("t5 still waiting", 32'(halted), 32'd0);
    @(negedge clk);
    chk("t5 timeout halted", 32'(halted), 32'd1);
    chk("t5 timeout code",   32'(halt_code), 32'd3);
    chk("t5 timeout cycle",  cycle_cnt, 32'd256);

    // Response in the last allowed WAIT cycle
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; imem_bus.req_ready = 1'b1;
    @(negedge clk);
    imem_bus.req_ready = 1'b0;
    repeat (254) @(negedge clk);
    imem_bus.rsp_valid = 1'b1; imem_bus.rsp_data = 32'h0050_0093;
    dp_next_pc = 32'h8000_0004;
    @(negedge clk);
    imem_bus.rsp_valid = 1'b0;
    chk("t5 late rsp wen",    32'(dp_wen), 32'd1);
    chk("t5 late rsp halted", 32'(halted), 32'd0);
    @(negedge clk);
    chk("t5 late pc",      dp_pc, 32'h8000_0004);
    chk("t5 late instret", instret, 32'd1);
    chk("t5 late cycle",   cycle_cnt, 32'd257);

    // Asynchronous reset during WAIT, then a stale response
    imem_bus.req_ready = 1'b1;
    @(negedge clk);
    imem_bus.req_ready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("t6 async");
    @(negedge clk);
    rst = 1'b1;
    imem_bus.rsp_valid = 1'b1; imem_bus.rsp_data = 32'hdead_beef;
    @(negedge clk);
    imem_bus.rsp_valid = 1'b0;
    chk_reset_outputs("t6 stale rsp");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6 idle start", 32'(imem_bus.req_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
